// File: rtl/binary_decoder_stream.sv
// Registered binary-to-N-line decoder (one-hot or thermometer) with valid/ready on both sides.
// A main output register plus one skid entry gives full throughput under backpressure.
module binary_decoder_stream #(
    parameter int IN_W       = 3,
    parameter int OUT_N      = 8,
    parameter int THERMO     = 0,
    parameter int ACTIVE_LOW = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_N-1:0] out,
    output logic             out_err
);

    localparam logic [OUT_N-1:0] IDLE = {OUT_N{1'(ACTIVE_LOW != 0)}};

    function automatic logic code_err(input logic [IN_W-1:0] c);
        return int'(c) >= OUT_N;
    endfunction

    // Stored words already carry the output polarity, so out is driven straight from a flop.
    function automatic logic [OUT_N-1:0] decode(input logic [IN_W-1:0] c);
        logic [OUT_N-1:0] w;
        w = '0;
        for (int k = 0; k < OUT_N; k++) begin
            if (THERMO != 0) w[k] = (k <= int'(c));
            else             w[k] = (k == int'(c));
        end
        if (code_err(c)) w = '0;
        if (ACTIVE_LOW != 0) w = ~w;
        return w;
    endfunction

    logic             main_vld_q, main_vld_d;
    logic [OUT_N-1:0] main_word_q, main_word_d;
    logic             main_err_q, main_err_d;
    logic             skid_vld_q, skid_vld_d;
    logic [OUT_N-1:0] skid_word_q, skid_word_d;
    logic             skid_err_q, skid_err_d;
    logic             in_ready_q;
    logic             accept;
    logic             drain;

    assign accept = in_valid && in_ready_q;
    assign drain  = main_vld_q && out_ready;

    always_comb begin
        main_vld_d  = main_vld_q;
        main_word_d = main_word_q;
        main_err_d  = main_err_q;
        skid_vld_d  = skid_vld_q;
        skid_word_d = skid_word_q;
        skid_err_d  = skid_err_q;
        if (skid_vld_q) begin
            // in_ready is low here, so only a drain can move things along.
            if (drain) begin
                main_word_d = skid_word_q;
                main_err_d  = skid_err_q;
                skid_vld_d  = 1'b0;
            end
        end else if (accept && (!main_vld_q || drain)) begin
            main_vld_d  = 1'b1;
            main_word_d = decode(in);
            main_err_d  = code_err(in);
        end else if (accept) begin
            skid_vld_d  = 1'b1;
            skid_word_d = decode(in);
            skid_err_d  = code_err(in);
        end else if (drain) begin
            main_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_vld_q  <= 1'b0;
            main_word_q <= IDLE;
            main_err_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            main_vld_q  <= main_vld_d;
            main_word_q <= main_word_d;
            main_err_q  <= main_err_d;
            skid_vld_q  <= skid_vld_d;
            in_ready_q  <= !skid_vld_d;
        end
    end

    // Skid payload is only read while skid_vld_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        skid_word_q <= skid_word_d;
        skid_err_q  <= skid_err_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld_q;
    assign out       = main_word_q;
    assign out_err   = main_err_q;

endmodule

// File: tb/tb_binary_decoder_stream.sv
// Bench for binary_decoder_stream: one-hot, thermometer (OUT_N=6) and active-low instances
// share one input stream; a negedge scoreboard tracks every accepted code per instance.
module tb_binary_decoder_stream;

    logic       clk;
    logic       rst_n;
    logic       vld;
    logic [2:0] code;
    logic       ordy;

    logic       ir_oh, ov_oh, er_oh;
    logic [7:0] out_oh;
    logic       ir_th, ov_th, er_th;
    logic [5:0] out_th;
    logic       ir_al, ov_al, er_al;
    logic [7:0] out_al;

    int n_tot;
    int n_bad;

    binary_decoder_stream u_oh (
        .clk(clk), .reset(rst_n), .in_valid(vld), .in_ready(ir_oh), .in(code),
        .out_valid(ov_oh), .out_ready(ordy), .out(out_oh), .out_err(er_oh)
    );

    binary_decoder_stream #(.IN_W(3), .OUT_N(6), .THERMO(1), .ACTIVE_LOW(0)) u_th (
        .clk(clk), .reset(rst_n), .in_valid(vld), .in_ready(ir_th), .in(code),
        .out_valid(ov_th), .out_ready(ordy), .out(out_th), .out_err(er_th)
    );

    binary_decoder_stream #(.IN_W(3), .OUT_N(8), .THERMO(0), .ACTIVE_LOW(1)) u_al (
        .clk(clk), .reset(rst_n), .in_valid(vld), .in_ready(ir_al), .in(code),
        .out_valid(ov_al), .out_ready(ordy), .out(out_al), .out_err(er_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instance j: 0 = one-hot/8, 1 = thermometer/6, 2 = one-hot/8 active-low. Returns {err, word}.
    function automatic logic [8:0] ref_word(input int j, input int c);
        int   outn;
        int   w;
        logic e;
        outn = (j == 1) ? 6 : 8;
        e    = (c >= outn);
        if (e)           w = 0;
        else if (j == 1) w = (1 << (c + 1)) - 1;
        else             w = 1 << c;
        if (j == 2) w = ~w & ((1 << outn) - 1);
        return {e, w[7:0]};
    endfunction

    logic [7:0] mo[3];
    logic       me[3];
    logic       mv[3];
    logic       mr[3];

    always_comb begin
        mo[0] = out_oh;          me[0] = er_oh; mv[0] = ov_oh; mr[0] = ir_oh;
        mo[1] = {2'b00, out_th}; me[1] = er_th; mv[1] = ov_th; mr[1] = ir_th;
        mo[2] = out_al;          me[2] = er_al; mv[2] = ov_al; mr[2] = ir_al;
    end

    logic [8:0] sb[3][16];
    int         wp[3];
    int         rp[3];
    logic [9:0] prev[3];
    logic       hold[3];

    // Inputs and outputs are stable at negedge, so the handshakes seen here are the ones the next posedge takes.
    initial begin
        for (int j = 0; j < 3; j++) begin
            wp[j] = 0; rp[j] = 0; hold[j] = 1'b0; prev[j] = '0;
        end
        forever begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                if (!rst_n) begin
                    wp[j] = 0; rp[j] = 0; hold[j] = 1'b0;
                end else begin
                    if (hold[j]) chk("hold", 32'({mv[j], me[j], mo[j]}), 32'(prev[j]));
                    if (mv[j] && ordy) begin
                        if (rp[j] == wp[j]) begin
                            chk("unexpected_word", 32'(1), 32'(0));
                        end else begin
                            chk("stream", 32'({me[j], mo[j]}), 32'(sb[j][rp[j] % 16]));
                            rp[j]++;
                        end
                    end
                    if (vld && mr[j]) begin
                        sb[j][wp[j] % 16] = ref_word(j, int'(code));
                        wp[j]++;
                    end
                    hold[j] = (mv[j] && !ordy) || (!mv[j] && !(vld && mr[j]));
                    prev[j] = {mv[j], me[j], mo[j]};
                end
            end
        end
    end

    logic [7:0] th_tab[8];
    logic [7:0] al_tab[8];
    logic [7:0] oh_exp;

    initial begin
        n_tot = 0;
        n_bad = 0;
        th_tab = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h00, 8'h00};
        al_tab = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        rst_n = 1'b0;
        vld   = 1'b0;
        code  = '0;
        ordy  = 1'b1;
        repeat (2) tick();

        chk("rst_valid", 32'(ov_oh), 32'(0));
        chk("rst_err", 32'(er_oh), 32'(0));
        chk("rst_ready", 32'(ir_oh), 32'(1));
        chk("rst_out_oh", 32'(out_oh), 32'h00);
        chk("rst_out_th", 32'(out_th), 32'h00);
        chk("rst_out_al", 32'(out_al), 32'hFF);
        rst_n = 1'b1;
        tick();

        // Continuous stream with no backpressure: one word per cycle, latency 1.
        for (int i = 0; i < 8; i++) begin
            code = 3'(i);
            vld  = 1'b1;
            tick();
            oh_exp = 8'(1 << i);
            chk("strm_valid", 32'(ov_oh), 32'(1));
            chk("strm_oh", 32'({er_oh, out_oh}), 32'({1'b0, oh_exp}));
            chk("strm_th", 32'({ov_th, er_th, out_th}), 32'({1'b1, i >= 6, th_tab[i][5:0]}));
            chk("strm_al", 32'({ov_al, er_al, out_al}), 32'({1'b1, 1'b0, al_tab[i]}));
        end
        vld = 1'b0;
        tick();
        chk("strm_end_valid", 32'(ov_oh), 32'(0));
        chk("strm_end_hold", 32'(out_oh), 32'h80);

        // Backpressure: second word goes to the skid, third waits.
        ordy = 1'b0;
        vld  = 1'b1;
        code = 3'd1;
        tick();
        chk("bp_a_out", 32'({ov_oh, out_oh}), 32'({1'b1, 8'h02}));
        chk("bp_a_ready", 32'(ir_oh), 32'(1));
        code = 3'd4;
        tick();
        chk("bp_b_ready", 32'(ir_oh), 32'(0));
        chk("bp_b_out", 32'(out_oh), 32'h02);
        code = 3'd6;
        tick();
        chk("bp_c_ready", 32'(ir_oh), 32'(0));
        chk("bp_c_out", 32'({ov_oh, out_oh}), 32'({1'b1, 8'h02}));
        ordy = 1'b1;
        tick();
        chk("bp_d_out", 32'({ov_oh, out_oh}), 32'({1'b1, 8'h10}));
        chk("bp_d_ready", 32'(ir_oh), 32'(1));
        tick();
        chk("bp_e_out", 32'({ov_oh, out_oh}), 32'({1'b1, 8'h40}));
        vld = 1'b0;
        tick();
        chk("bp_f_valid", 32'(ov_oh), 32'(0));

        // Asynchronous reset with both entries occupied.
        ordy = 1'b0;
        vld  = 1'b1;
        code = 3'd3;
        tick();
        code = 3'd5;
        tick();
        chk("full_ready", 32'(ir_oh), 32'(0));
        vld   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'({ov_oh, ov_th, ov_al}), 32'(0));
        chk("arst_out_oh", 32'(out_oh), 32'h00);
        chk("arst_out_al", 32'(out_al), 32'hFF);
        chk("arst_ready", 32'(ir_oh), 32'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ordy  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_valid", 32'({ov_oh, ov_th, ov_al}), 32'(0));
            chk("post_rst_out", 32'({out_oh, out_al}), 32'h00FF);
        end

        // Random handshakes; the scoreboard checks order, content and stability.
        for (int n = 0; n < 10000; n++) begin
            vld  = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            code = 3'($urandom_range(0, 7));
            tick();
        end
        vld  = 1'b0;
        ordy = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (rp[0] == wp[0] && rp[1] == wp[1] && rp[2] == wp[2]) break;
            tick();
        end
        for (int j = 0; j < 3; j++) chk("drain_empty", 32'(rp[j]), 32'(wp[j]));
        chk("rand_traffic", 32'(wp[0] > 1000), 32'(1));

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
